// File: rtl/video_pkg.sv
// Shared widths, bandwidth codes and the slot-hit decode for the video DRAM feeder.
package video_pkg;

    localparam int VID_AW = 21;
    localparam int VID_DW = 16;

    localparam logic [1:0] BW_1_8 = 2'b00;
    localparam logic [1:0] BW_1_4 = 2'b01;
    localparam logic [1:0] BW_1_2 = 2'b10;

    // Code 2'b11 has no rate of its own and runs at the 1/2 rate.
    function automatic logic slot_hit(input logic [2:0] slot, input logic [1:0] bw);
        logic hit;
        case (bw)
            BW_1_8:  hit = (slot == 3'd0);
            BW_1_4:  hit = (slot[1:0] == 2'd0);
            default: hit = ~slot[0];
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/video_slot_gen.sv
// Eight-entry DRAM slot counter; flags when the upcoming cycle belongs to video.
module video_slot_gen
    import video_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cend,
    input  logic       video_go,
    input  logic [1:0] video_bw,
    output logic       video_slot
);

    logic [2:0] slot_ctr_q;
    logic [2:0] slot_ctr_d;
    logic [2:0] slot_next;

    always_comb begin
        slot_next  = slot_ctr_q + 3'd1;
        slot_ctr_d = cend ? slot_next : slot_ctr_q;
        video_slot = video_go && slot_hit(slot_next, video_bw);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_ctr_q <= 3'd0;
        end else begin
            slot_ctr_q <= slot_ctr_d;
        end
    end

endmodule

// File: rtl/video_dram_feeder.sv
// Video fetch responder in the DRAM arbiter: reserves slots, issues reads, strobes words back.
// Define VIDEO_ADDR_WRAP_EN to confine the address increment to the low WRAP_BITS bits.
module video_dram_feeder
    import video_pkg::*;
#(
    parameter int AW        = VID_AW,
    parameter int WRAP_BITS = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cend,
    input  logic              pre_cend,
    input  logic              video_go,
    input  logic [1:0]        video_bw,
    input  logic              addr_load,
    input  logic [AW-1:0]     addr_base,
    output logic              vid_req,
    output logic [AW-1:0]     vid_addr,
    input  logic              dram_rdstb,
    input  logic [VID_DW-1:0] dram_rddata,
    output logic              video_strobe,
    output logic [VID_DW-1:0] video_data,
    output logic              video_slot,
    output logic              vid_err
);

`ifdef VIDEO_ADDR_WRAP_EN
    localparam bit ADDR_WRAP = 1'b1;
`else
    localparam bit ADDR_WRAP = 1'b0;
`endif
    localparam logic [AW-1:0] LOW_MASK = (AW'(1) << WRAP_BITS) - AW'(1);
    // Bits allowed to change on increment; the rest are held.
    localparam logic [AW-1:0] INC_MASK = ADDR_WRAP ? LOW_MASK : '1;

    logic              vid_req_q,      vid_req_d;
    logic [AW-1:0]     vaddr_q,        vaddr_d;
    logic              pending_q,      pending_d;
    logic              video_strobe_q, video_strobe_d;
    logic [VID_DW-1:0] video_data_q,   video_data_d;
    logic              vid_err_q,      vid_err_d;
    logic [AW-1:0]     vaddr_inc;
    logic              rd_hit;

    video_slot_gen u_slot_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .cend       (cend),
        .video_go   (video_go),
        .video_bw   (video_bw),
        .video_slot (video_slot)
    );

    // NOTE: every signal gets a default at the top of the block so no latch can be inferred.
    always_comb begin
        vaddr_inc      = (vaddr_q & ~INC_MASK) | ((vaddr_q + AW'(1)) & INC_MASK);
        rd_hit         = dram_rdstb && pre_cend;
        vid_req_d      = vid_req_q;
        vaddr_d        = vaddr_q;
        pending_d      = pending_q;
        video_strobe_d = 1'b0;
        video_data_d   = video_data_q;
        vid_err_d      = vid_err_q;

        if (cend) begin
            vid_req_d = video_slot;
            if (vid_req_q) begin
                pending_d = 1'b1;
                vaddr_d   = vaddr_inc;
                if (pending_q) begin
                    vid_err_d = 1'b1;
                end
            end
        end

        // pre_cend and cend never coincide, so this cannot fight the grant above.
        if (rd_hit) begin
            if (pending_q) begin
                video_data_d   = dram_rddata;
                video_strobe_d = 1'b1;
                pending_d      = 1'b0;
            end else begin
                vid_err_d = 1'b1;
            end
        end

        if (addr_load) begin
            vaddr_d = addr_base;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_req_q      <= 1'b0;
            vaddr_q        <= '0;
            pending_q      <= 1'b0;
            video_strobe_q <= 1'b0;
            video_data_q   <= '0;
            vid_err_q      <= 1'b0;
        end else begin
            vid_req_q      <= vid_req_d;
            vaddr_q        <= vaddr_d;
            pending_q      <= pending_d;
            video_strobe_q <= video_strobe_d;
            video_data_q   <= video_data_d;
            vid_err_q      <= vid_err_d;
        end
    end

    assign vid_req      = vid_req_q;
    assign vid_addr     = vaddr_q;
    assign video_strobe = video_strobe_q;
    assign video_data   = video_data_q;
    assign vid_err      = vid_err_q;

endmodule

// File: tb/tb_video_dram_feeder.sv
// Self-checking bench for video_dram_feeder: DRAM-cycle driver, behavioural model, data scoreboard.
module tb_video_dram_feeder;
    import video_pkg::*;

    localparam int AW = VID_AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cend, pre_cend, video_go, addr_load, dram_rdstb;
    logic [1:0]    video_bw;
    logic [AW-1:0] addr_base;
    logic [15:0]   dram_rddata;
    logic          vid_req, video_strobe, video_slot, vid_err;
    logic [AW-1:0] vid_addr;
    logic [15:0]   video_data;

    video_dram_feeder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cend         (cend),
        .pre_cend     (pre_cend),
        .video_go     (video_go),
        .video_bw     (video_bw),
        .addr_load    (addr_load),
        .addr_base    (addr_base),
        .vid_req      (vid_req),
        .vid_addr     (vid_addr),
        .dram_rdstb   (dram_rdstb),
        .dram_rddata  (dram_rddata),
        .video_strobe (video_strobe),
        .video_data   (video_data),
        .video_slot   (video_slot),
        .vid_err      (vid_err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Bench-side view of the DRAM schedule and the feeder's expected state.
    int unsigned   ts;
    logic          exp_req, exp_pend, exp_err, rd_due;
    logic [AW-1:0] exp_addr;
    logic [15:0]   last_data;
    logic [15:0]   sb_q[$];
    int            n_req, n_stb;

    // Per-cycle stimulus knobs.
    logic          g_go, g_ld_cend, g_stray, g_drop, g_early;
    logic [1:0]    g_bw;
    logic [AW-1:0] g_base;

`ifdef VIDEO_ADDR_WRAP_EN
    localparam logic [AW-1:0] WRAP_EXP = 21'h00000;
`else
    localparam logic [AW-1:0] WRAP_EXP = 21'h02000;
`endif

    typedef struct {
        logic [1:0]    bw;
        logic [AW-1:0] base;
        int            n;
        int            reqs;
        int            stbs;
        logic [AW-1:0] end_addr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic tb_hit(input int unsigned s, input logic [1:0] bw);
        int unsigned period;
        period = (bw == 2'b00) ? 8 : (bw == 2'b01) ? 4 : 2;
        return (s % period) == 0;
    endfunction

    function automatic logic [AW-1:0] tb_next_addr(input logic [AW-1:0] a);
`ifdef VIDEO_ADDR_WRAP_EN
        logic [12:0] lo;
        lo = a[12:0] + 13'd1;
        return {a[AW-1:13], lo};
`else
        return a + 21'd1;
`endif
    endfunction

    task automatic idle_inputs();
        cend        = 1'b0;
        pre_cend    = 1'b0;
        dram_rdstb  = 1'b0;
        dram_rddata = 16'h0;
        addr_load   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        video_go  = 1'b0;
        video_bw  = 2'b00;
        addr_base = '0;
        rst_n     = 1'b0;
        #7;
        check("rst_vid_req",      32'(vid_req),      32'd0);
        check("rst_vid_addr",     32'(vid_addr),     32'd0);
        check("rst_video_strobe", 32'(video_strobe), 32'd0);
        check("rst_video_data",   32'(video_data),   32'd0);
        check("rst_video_slot",   32'(video_slot),   32'd0);
        check("rst_vid_err",      32'(vid_err),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ts = 0; exp_req = 0; exp_pend = 0; exp_err = 0; rd_due = 0;
        exp_addr = '0; last_data = '0;
        sb_q.delete();
        n_req = 0; n_stb = 0;
        g_go = 0; g_ld_cend = 0; g_stray = 0; g_drop = 0; g_early = 0;
        g_bw = 2'b00; g_base = '0;
    endtask

    task automatic load_addr(input logic [AW-1:0] base);
        addr_load = 1'b1;
        addr_base = base;
        @(posedge clk); #1;
        addr_load = 1'b0;
        exp_addr  = base;
        @(negedge clk);
        check("vid_addr_load", 32'(vid_addr), 32'(base));
        @(posedge clk); #1;
    endtask

    // One DRAM cycle of four clks: phase 2 is pre_cend, phase 3 is cend.
    task automatic dram_cycle();
        logic        rd_now, stb_exp, slot_exp;
        logic [15:0] d;
        rd_now   = (rd_due && !g_drop) || g_stray;
        stb_exp  = 1'b0;
        slot_exp = g_go && tb_hit((ts + 1) % 8, g_bw);
        for (int p = 0; p < 4; p++) begin
            video_go    = g_go;
            video_bw    = g_bw;
            pre_cend    = (p == 2);
            cend        = (p == 3);
            addr_load   = (p == 3) && g_ld_cend;
            addr_base   = g_base;
            dram_rdstb  = ((p == 2) && rd_now) || ((p == 0) && g_early);
            d           = 16'($urandom_range(1, 65535));
            dram_rddata = d;
            if (p == 2 && rd_now) begin
                if (exp_pend) begin
                    sb_q.push_back(d);
                    last_data = d;
                    stb_exp   = 1'b1;
                    exp_pend  = 1'b0;
                end else begin
                    exp_err = 1'b1;
                end
            end
            @(negedge clk);
            if (p == 0) begin
                check("vid_req",         32'(vid_req),    32'(exp_req));
                check("vid_addr",        32'(vid_addr),   32'(exp_addr));
                check("vid_err",         32'(vid_err),    32'(exp_err));
                if (!stb_exp) check("video_data_hold", 32'(video_data), 32'(last_data));
                if (vid_req) n_req++;
            end
            if (p == 3) check("video_slot", 32'(video_slot), 32'(slot_exp));
            check("video_strobe", 32'(video_strobe), 32'((p == 3) && stb_exp));
            if (video_strobe) begin
                n_stb++;
                if (sb_q.size() == 0) check("strobe_without_data", 32'(video_strobe), 32'd0);
                else check("video_data", 32'(video_data), 32'(sb_q.pop_front()));
            end
            @(posedge clk); #1;
        end
        if (exp_req) begin
            if (exp_pend) exp_err = 1'b1;
            exp_pend = 1'b1;
            exp_addr = tb_next_addr(exp_addr);
        end
        if (g_ld_cend) exp_addr = g_base;
        rd_due  = exp_req;
        exp_req = slot_exp;
        ts      = (ts + 1) % 8;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vecs[0] = '{2'b01, 21'h00100, 16, 4, 4, 21'h00104};
        vecs[1] = '{2'b00, 21'h00040,  8, 1, 1, 21'h00041};
        vecs[2] = '{2'b10, 21'h001F0,  8, 4, 4, 21'h001F4};
        vecs[3] = '{2'b11, 21'h00000,  8, 4, 4, 21'h00004};
        vecs[4] = '{2'b10, 21'h00300,  2, 1, 1, 21'h00301};

        // Table: go high for n cend's, then three drain cycles with go low.
        for (int i = 0; i < 5; i++) begin
            do_reset();
            load_addr(vecs[i].base);
            g_bw = vecs[i].bw;
            g_go = 1'b1;
            repeat (vecs[i].n) dram_cycle();
            g_go = 1'b0;
            repeat (3) dram_cycle();
            check($sformatf("v%0d_req_count", i),    32'(n_req),       32'(vecs[i].reqs));
            check($sformatf("v%0d_strobe_count", i), 32'(n_stb),       32'(vecs[i].stbs));
            check($sformatf("v%0d_end_addr", i),     32'(vid_addr),    32'(vecs[i].end_addr));
            check($sformatf("v%0d_no_err", i),       32'(vid_err),     32'd0);
            check($sformatf("v%0d_sb_empty", i),     32'(sb_q.size()), 32'd0);
        end

        // addr_load on the same cend as an increment wins; the pending read survives.
        do_reset();
        load_addr(21'h00010);
        g_bw = 2'b10; g_go = 1'b1;
        repeat (2) dram_cycle();
        g_ld_cend = 1'b1; g_base = 21'h02000;
        dram_cycle();
        g_ld_cend = 1'b0;
        @(negedge clk);
        check("load_beats_inc", 32'(vid_addr), 32'h2000);
        @(posedge clk); #1;
        g_go = 1'b0;
        repeat (2) dram_cycle();
        check("load_keeps_pending", 32'(n_stb), 32'd1);

        // Address increment across the WRAP_BITS boundary.
        do_reset();
        load_addr(21'h01FFF);
        g_bw = 2'b10; g_go = 1'b1;
        repeat (3) dram_cycle();
        g_go = 1'b0;
        @(negedge clk);
        check("wrap_addr", 32'(vid_addr), 32'(WRAP_EXP));
        @(posedge clk); #1;
        repeat (2) dram_cycle();

        // Missing read data followed by another grant flags an error.
        do_reset();
        g_bw = 2'b10; g_go = 1'b1;
        repeat (3) dram_cycle();
        g_drop = 1'b1;
        dram_cycle();
        g_drop = 1'b0;
        dram_cycle();
        g_go = 1'b0;
        repeat (3) dram_cycle();
        check("grant_while_pending_err", 32'(vid_err), 32'd1);
        check("grant_while_pending_stb", 32'(n_stb),   32'd1);

        // Stray read strobe with nothing pending.
        do_reset();
        g_stray = 1'b1;
        dram_cycle();
        g_stray = 1'b0;
        dram_cycle();
        check("stray_rdstb_err", 32'(vid_err), 32'd1);
        check("stray_rdstb_stb", 32'(n_stb),   32'd0);

        // Early rdstb ignored, then async reset while a read is pending.
        do_reset();
        g_bw = 2'b10; g_go = 1'b1;
        repeat (3) dram_cycle();
        g_early = 1'b1;
        dram_cycle();
        g_early = 1'b0;
        dram_cycle();
        check("early_rdstb_strobes", 32'(n_stb), 32'd1);
        video_go = 1'b1; video_bw = 2'b10;
        @(posedge clk); #1;
        check("pre_rst_slot", 32'(video_slot), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vid_req",      32'(vid_req),      32'd0);
        check("mid_rst_vid_addr",     32'(vid_addr),     32'd0);
        check("mid_rst_video_strobe", 32'(video_strobe), 32'd0);
        check("mid_rst_video_data",   32'(video_data),   32'd0);
        check("mid_rst_video_slot",   32'(video_slot),   32'd0);
        check("mid_rst_vid_err",      32'(vid_err),      32'd0);
        do_reset();
        repeat (2) dram_cycle();
        g_stray = 1'b1;
        dram_cycle();
        g_stray = 1'b0;
        dram_cycle();
        check("rst_drops_pending_err", 32'(vid_err), 32'd1);
        check("rst_drops_pending_stb", 32'(n_stb),   32'd0);
        g_bw = 2'b10; g_go = 1'b1;
        repeat (3) dram_cycle();
        g_go = 1'b0;
        repeat (2) dram_cycle();
        check("restart_req_count", 32'(n_req), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
